// File: rtl/mkalc_io_bus.sv
// Address decoder and memory-mapped I/O page (LED, keyboard latch, timer, 7-seg scan) for the mkalc core.
// Optional interval timer is built only when MKALC_IO_TIMER_EN is defined.
module mkalc_io_bus #(
    parameter int RAM_AW   = 12,
    parameter int PRESCALE = 25000,
    parameter int SCAN_DIV = 25000
) (
    input  logic              clock_25,
    input  logic              reset_n,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_q,
    input  logic [7:0]        key_code,
    input  logic              key_strobe,
    output logic [7:0]        led,
    output logic [7:0]        seg,
    output logic [3:0]        dig
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic              ram_sel_r;
    logic [7:0]        io_rdata_r;
    logic [15:0]       prev_addr_r;
    logic [7:0]        led_r;
    logic [7:0]        key_r;
    logic              ready_r;
    logic              ovf_r;
    logic [7:0]        digit_r [4];
    logic [SW-1:0]     scan_r;
    logic [1:0]        slot_r;

    logic              ram_hit_s;
    logic              io_hit_s;
    logic              wr_io_s;
    logic              wr_status_s;
    logic              key_rd_s;
    logic              ready_eff_s;
    logic [7:0]        key_nxt_s;
    logic              ready_nxt_s;
    logic              ovf_nxt_s;
    logic [7:0]        io_byte_s;
    logic              tick_s;
    logic [7:0]        reload_s;

    assign ram_hit_s   = (cpu_addr < 16'hC000);
    assign io_hit_s    = (cpu_addr[15:8] == 8'hC0) && (cpu_addr[7:3] == 5'd0);
    assign wr_io_s     = cpu_wr && io_hit_s;
    assign wr_status_s = wr_io_s && (cpu_addr[2:0] == 3'd2);

    assign ram_addr  = cpu_addr[RAM_AW-1:0];
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_wr && ram_hit_s;

    assign cpu_rdata = ram_sel_r ? ram_q : io_rdata_r;
    assign led       = led_r;
    assign seg       = ~digit_r[slot_r];
    assign dig       = ~(4'b0001 << slot_r);

`ifdef MKALC_IO_TIMER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_r, pre_nxt_s;
    logic [7:0]    cnt_r, cnt_nxt_s;
    logic [7:0]    reload_r, reload_nxt_s;
    logic          tick_r, tick_nxt_s;
    logic          ms_s;
    logic          wr_reload_s;

    assign ms_s        = (pre_r == PW'(PRESCALE - 1));
    assign wr_reload_s = wr_io_s && (cpu_addr[2:0] == 3'd3);
    assign tick_s      = tick_r;
    assign reload_s    = reload_r;

    // Timer next state; a RELOAD write takes priority over a pending countdown step
    always_comb begin
        pre_nxt_s    = ms_s ? '0 : pre_r + PW'(1);
        cnt_nxt_s    = cnt_r;
        reload_nxt_s = reload_r;
        tick_nxt_s   = wr_status_s ? 1'b0 : tick_r;
        if (wr_reload_s) begin
            reload_nxt_s = cpu_wdata;
            cnt_nxt_s    = cpu_wdata;
            pre_nxt_s    = '0;
        end else if (ms_s && (reload_r != 8'd0)) begin
            if (cnt_r == 8'd1) begin
                tick_nxt_s = 1'b1;
                cnt_nxt_s  = reload_r;
            end else begin
                cnt_nxt_s = cnt_r - 8'd1;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Timer state registers
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            pre_r    <= '0;
            cnt_r    <= 8'd0;
            reload_r <= 8'd0;
            tick_r   <= 1'b0;
        end else begin
            pre_r    <= pre_nxt_s;
            cnt_r    <= cnt_nxt_s;
            reload_r <= reload_nxt_s;
            tick_r   <= tick_nxt_s;
        end
    end
`else
    assign tick_s   = 1'b0;
    assign reload_s = 8'd0;
`endif

    // Keyboard latch; a strobe coinciding with the KEY-read clear latches the new code
    always_comb begin
        key_rd_s    = (cpu_addr == 16'hC001) && !cpu_wr && (prev_addr_r != 16'hC001);
        ready_eff_s = ready_r && !key_rd_s;
        key_nxt_s   = key_r;
        ready_nxt_s = ready_eff_s;
        ovf_nxt_s   = wr_status_s ? 1'b0 : ovf_r;
        if (key_strobe) begin
            if (!ready_eff_s) begin
                key_nxt_s   = key_code;
                ready_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = 1'b1;
            end
        end else begin
            ready_nxt_s = ready_eff_s;
        end
    end

    // I/O page read byte, captured with the address for one-clock read latency
    always_comb begin
        io_byte_s = 8'hFF;
        if (io_hit_s) begin
            case (cpu_addr[2:0])
                3'd0:    io_byte_s = led_r;
                3'd1:    io_byte_s = key_r;
                3'd2:    io_byte_s = {tick_s, 5'd0, ovf_r, ready_r};
                3'd3:    io_byte_s = reload_s;
                default: io_byte_s = digit_r[cpu_addr[1:0]];
            endcase
        end else begin
            io_byte_s = 8'hFF;
        end
    end

    // Bus, register file and keyboard state
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            ram_sel_r   <= 1'b1;
            io_rdata_r  <= 8'd0;
            prev_addr_r <= 16'd0;
            led_r       <= 8'd0;
            key_r       <= 8'd0;
            ready_r     <= 1'b0;
            ovf_r       <= 1'b0;
            for (int i = 0; i < 4; i++) digit_r[i] <= 8'd0;
        end else begin
            ram_sel_r   <= ram_hit_s;
            io_rdata_r  <= io_byte_s;
            prev_addr_r <= cpu_addr;
            key_r       <= key_nxt_s;
            ready_r     <= ready_nxt_s;
            ovf_r       <= ovf_nxt_s;
            if (wr_io_s && (cpu_addr[2:0] == 3'd0)) led_r <= cpu_wdata;
            if (wr_io_s && cpu_addr[2]) digit_r[cpu_addr[1:0]] <= cpu_wdata;
        end
    end

    // Display scan: one digit slot per SCAN_DIV clocks
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            scan_r <= '0;
            slot_r <= 2'd0;
        end else if (scan_r == SW'(SCAN_DIV - 1)) begin
            scan_r <= '0;
            slot_r <= slot_r + 2'd1;
        end else begin
            scan_r <= scan_r + SW'(1);
        end
    end

endmodule

// File: doc/mkalc_io_bus.md
# mkalc_io_bus

Address decoder and memory-mapped I/O stage directly downstream of the 8-bit processor core in the mkalc design. It splits the core's 16-bit bus between an external synchronous block RAM and a small I/O page. The I/O page holds an LED latch, a keyboard code latch with ready/overflow flags, a 1 ms-based interval timer, and a 4-digit multiplexed 7-segment display. It returns the read byte to the core's data input.

## Interface
Parameters:
- RAM_AW, 12: RAM address width; RAM occupies $0000–$BFFF and is mirrored every 2^RAM_AW bytes.
- PRESCALE, 25000: clocks per timer millisecond.
- SCAN_DIV, 25000: clocks per display digit slot.

Ports:
- clock_25  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  core address
- cpu_wdata  in  8  core write data
- cpu_wr  in  1  core write strobe, level, sampled each edge
- cpu_rdata  out  8  read data to core
- ram_addr  out  RAM_AW  cpu_addr[RAM_AW-1:0], combinational
- ram_wdata  out  8  cpu_wdata, combinational
- ram_we  out  1  cpu_wr & (cpu_addr < $C000), combinational
- ram_q  in  8  RAM read data, one-clock latency
- key_code  in  8  keyboard scanner code
- key_strobe  in  1  one-clock pulse, key_code valid
- led  out  8  LED latch
- seg  out  8  segment drive, active-low
- dig  out  4  digit select, active-low, one-hot-zero

## Operation
- Map:
  - $0000–$BFFF is RAM.
  - $C000–$C0FF is the I/O page. Offsets $00–$07 are used; other offsets read $FF and ignore writes.
  - $C100–$FFFF reads $FF and ignores writes.
- Registers:
  - $C000 LED (RW).
  - $C001 KEY (RO): latched code. A read clears ready.
  - $C002 STATUS (RO bits): bit0 ready, bit1 overflow, bit7 tick, other bits 0. A write of any value clears bit1 and bit7.
  - $C003 RELOAD (RW): timer period in ms. Value 0 disables the timer.
  - $C004–$C007 DIGIT0–3 (RW): segment pattern, 1 = segment lit.
- Keyboard, on key_strobe:
  - If ready=0: latch key_code and set ready=1.
  - If ready=1: keep the old code and set overflow=1.
- KEY read side effect fires only on the first clock that cpu_addr equals $C001 with cpu_wr=0. The previous-cycle address register must differ. A held address never clears twice.
- Timer:
  - Prescaler counts 0..PRESCALE-1 and emits ms_strobe on wrap.
  - On ms_strobe with RELOAD≠0: if cnt==1, set tick=1 and cnt=RELOAD; else cnt−1.
  - A write to $C003 loads cnt=new value and clears the prescaler.
- Display:
  - Scan counter advances slot 0→1→2→3→0 every SCAN_DIV clocks.
  - dig = ~(1<<slot); seg = ~DIGITslot.

## Timing
- Reads have one-clock latency. The region select and the I/O read byte are registered at the edge where cpu_addr is presented. cpu_rdata in the next cycle is ram_q (RAM region), the registered I/O byte, or $FF.
- Writes take effect at the edge where cpu_wr=1. A read of the same register in the following cycle returns the new value.
- Reset values:
  - Outputs: led=$00, seg=$FF, dig=4'b1110.
  - State: all registers 0, region select=RAM, so cpu_rdata follows ram_q. ram_* outputs stay combinational during reset.
- Simultaneous events:
  - Strobe and KEY read clear in the same cycle: the new code is latched and ready stays 1.
  - STATUS write and tick event in the same cycle: tick=1.
  - STATUS write and overflowing strobe in the same cycle: overflow=1.
  - RELOAD write and cnt==1 ms_strobe in the same cycle: the write wins and no tick is set.
- Reset asserted mid-operation clears everything immediately, with no completion of a pending write.

## Configuration
- MKALC_IO_TIMER_EN defined: prescaler, cnt, RELOAD and tick are built as above.
- MKALC_IO_TIMER_EN undefined:
  - No timer logic is built.
  - $C003 reads $00 and ignores writes.
  - STATUS bit7 is always 0.
  - The STATUS write still clears overflow.

## Test plan
- Reset, then check led=$00, seg=$FF, dig=1110. Write $5A to $C000 → led=$5A next cycle; read $C000 → cpu_rdata=$5A one clock after the address.
- RAM path: write $33 to $1234 → ram_we=1, ram_addr=$234 (RAM_AW=12). Read $1234 with ram_q driven $33 → cpu_rdata=$33 one clock later.
- Keyboard:
  - Strobe code $41 → STATUS=$01.
  - Strobe $42 → STATUS=$03 and KEY=$41.
  - Hold address $C001 three cycles plus a strobe at the second cycle → ready stays 1 and KEY=$42 on the next read.
- Timer (PRESCALE=4 in bench): write RELOAD=$03 → tick set exactly 12 clocks later. Write $00 to $C002 → bit7 clears. Define the macro off → $C003 reads $00 and no tick ever appears.
- Display (SCAN_DIV=2): DIGIT0–3 = $01,$02,$04,$08 → seg/dig sequence $FE/1110, $FD/1101, $FB/1011, $F7/0111, repeating every 8 clocks.
- Unmapped: read $C010 and $F000 → $FF. Write there → no register or LED change.
